// File: rtl/alu_logic_arbiter.sv
// Round-robin arbiter sharing one 32-bit bitwise logic unit (AND/OR/XOR/ANDN) among NUM_REQ requesters.
// Defining ALU_ARB_PERF_EN adds a saturating grant counter with a synchronous clear.
module alu_logic_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_operandA,
  input  logic [32*NUM_REQ-1:0] req_operandB,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id
`ifdef ALU_ARB_PERF_EN
  ,
  input  logic                  perf_clear,
  output logic [15:0]           perf_grant_count
`endif
);

  function automatic logic [31:0] logic_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      2'b00:   logic_op = a & b;
      2'b01:   logic_op = a | b;
      2'b10:   logic_op = a ^ b;
      2'b11:   logic_op = a & ~b;
      default: logic_op = 32'h0000_0000;
    endcase
  endfunction

  logic              out_free_s;
  logic              grant_found_s;
  logic              hit_s;
  logic [ID_W:0]     sum_s;
  logic [ID_W-1:0]   idx_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic [ID_W-1:0]   next_ptr_s;
  logic [1:0]        sel_op_s;
  logic [31:0]       sel_a_s;
  logic [31:0]       sel_b_s;
  logic [ID_W-1:0]   rr_ptr_r;
  logic              resp_valid_r;
  logic [31:0]       resp_data_r;
  logic [ID_W-1:0]   resp_id_r;

  assign out_free_s = ~resp_valid_r | resp_ready;

  // Scan requesters starting at rr_ptr; the first valid one wins while the result slot is free.
  always_comb begin
    req_ready     = '0;
    grant_found_s = 1'b0;
    hit_s         = 1'b0;
    sum_s         = '0;
    idx_s         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
      idx_s = (sum_s >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum_s - (ID_W+1)'(NUM_REQ)) : ID_W'(sum_s);
      hit_s = out_free_s & ~grant_found_s & req_valid[idx_s];
      req_ready[idx_s] = hit_s;
      grant_found_s    = grant_found_s | hit_s;
    end
  end

  // One-hot grant steers the winner's opcode, operands and index.
  always_comb begin
    sel_op_s    = 2'b00;
    sel_a_s     = 32'h0000_0000;
    sel_b_s     = 32'h0000_0000;
    grant_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_op_s    = sel_op_s    | ({2{req_ready[i]}}    & req_op[2*i +: 2]);
      sel_a_s     = sel_a_s     | ({32{req_ready[i]}}   & req_operandA[32*i +: 32]);
      sel_b_s     = sel_b_s     | ({32{req_ready[i]}}   & req_operandB[32*i +: 32]);
      grant_idx_s = grant_idx_s | ({ID_W{req_ready[i]}} & ID_W'(i));
    end
    next_ptr_s = (grant_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + ID_W'(1);
  end

  // Result register and round-robin pointer; pointer only advances on an accepted request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'h0000_0000;
      resp_id_r    <= '0;
      rr_ptr_r     <= '0;
    end else if (grant_found_s) begin
      resp_valid_r <= 1'b1;
      resp_data_r  <= logic_op(sel_op_s, sel_a_s, sel_b_s);
      resp_id_r    <= grant_idx_s;
      rr_ptr_r     <= next_ptr_s;
    end else if (resp_ready) begin
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= resp_valid_r;
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_id    = resp_id_r;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf_cnt_r;

  // Saturating count of accepted requests; clear wins over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_cnt_r <= 16'h0000;
    end else if (perf_clear) begin
      perf_cnt_r <= 16'h0000;
    end else if (grant_found_s && (perf_cnt_r != 16'hFFFF)) begin
      perf_cnt_r <= perf_cnt_r + 16'h0001;
    end else begin
      perf_cnt_r <= perf_cnt_r;
    end
  end

  assign perf_grant_count = perf_cnt_r;
`endif

endmodule
